// File: rtl/rc4_stream_encryptor_if.sv
// Bundles the S-RAM port, the plaintext stream and the ciphertext stream.
interface rc4_stream_encryptor_if #(
  parameter int unsigned MSG_WIDTH = 8
);
  logic [MSG_WIDTH-1:0] s_addr;
  logic [MSG_WIDTH-1:0] s_wdata;
  logic                 s_wren;
  logic [MSG_WIDTH-1:0] s_rdata;
  logic [MSG_WIDTH-1:0] pt_data;
  logic                 pt_valid;
  logic                 pt_ready;
  logic [MSG_WIDTH-1:0] ct_data;
  logic                 ct_valid;
  logic                 ct_ready;

  // Engine side
  modport master (
    output s_addr, s_wdata, s_wren, pt_ready, ct_data, ct_valid,
    input  s_rdata, pt_data, pt_valid, ct_ready
  );

  // RAM / source / sink side
  modport slave (
    input  s_addr, s_wdata, s_wren, pt_ready, ct_data, ct_valid,
    output s_rdata, pt_data, pt_valid, ct_ready
  );
endinterface

// File: rtl/rc4_stream_encryptor.sv
// RC4 PRGA transmit engine: walks a pre-permuted S-box RAM, produces one
// keystream byte per message byte and XORs it onto a valid/ready plaintext
// stream to produce a valid/ready ciphertext stream.
module rc4_stream_encryptor #(
  parameter int unsigned MSG_WIDTH = 8,
  parameter int unsigned MSG_LEN   = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  rc4_stream_encryptor_if.master bus,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MSG_LEN - 1);

  typedef enum logic [3:0] {
    IDLE, RD_I, LAT_I, RD_J, LAT_J, WR_I, WR_J, RD_K, LAT_K, GET_PT, SEND, DONE
  } state_t;

  state_t               state_q, state_d;
  logic [MSG_WIDTH-1:0] i_q, i_d, j_q, j_d;
  logic [MSG_WIDTH-1:0] si_q, si_d, sj_q, sj_d, k_q, k_d, ct_q, ct_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [MSG_WIDTH-1:0] s_addr_q, s_addr_d, s_wdata_q, s_wdata_d;
  logic [MSG_WIDTH-1:0] ct_data_q, ct_data_d;
  logic                 s_wren_q, s_wren_d, pt_ready_q, pt_ready_d;
  logic                 ct_valid_q, ct_valid_d, busy_q, busy_d, done_q, done_d;

  // Next-state / datapath update, then outputs decoded from the next state so they register in step
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    si_d    = si_q;
    sj_d    = sj_q;
    k_d     = k_q;
    ct_d    = ct_q;
    count_d = count_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          i_d     = MSG_WIDTH'(1);
          j_d     = '0;
          count_d = '0;
          state_d = RD_I;
        end
      end
      RD_I:  state_d = LAT_I;
      LAT_I: begin
        si_d    = bus.s_rdata;
        j_d     = j_q + bus.s_rdata;
        state_d = RD_J;
      end
      RD_J:  state_d = LAT_J;
      LAT_J: begin
        sj_d    = bus.s_rdata;
        state_d = WR_I;
      end
      WR_I:  state_d = WR_J;
      WR_J:  state_d = RD_K;
      RD_K:  state_d = LAT_K;
      LAT_K: begin
        k_d     = bus.s_rdata;
        state_d = GET_PT;
      end
      GET_PT: begin
        if (bus.pt_valid) begin
          ct_d    = bus.pt_data ^ k_q;
          state_d = SEND;
        end
      end
      SEND: begin
        if (bus.ct_ready) begin
          count_d = count_q + CNT_W'(1);
          if (count_q == LAST_CNT) begin
            state_d = DONE;
          end else begin
            i_d     = i_q + MSG_WIDTH'(1);
            state_d = RD_I;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    s_addr_d   = '0;
    s_wdata_d  = '0;
    s_wren_d   = 1'b0;
    pt_ready_d = 1'b0;
    ct_valid_d = 1'b0;
    ct_data_d  = '0;
    busy_d     = (state_d != IDLE) && (state_d != DONE);
    done_d     = (state_d == DONE);

    case (state_d)
      RD_I: s_addr_d = i_d;
      RD_J: s_addr_d = j_d;
      WR_I: begin
        s_addr_d  = i_d;
        s_wdata_d = sj_d;
        s_wren_d  = 1'b1;
      end
      WR_J: begin
        s_addr_d  = j_d;
        s_wdata_d = si_d;
        s_wren_d  = 1'b1;
      end
      RD_K:   s_addr_d = si_d + sj_d;
      GET_PT: pt_ready_d = 1'b1;
      SEND: begin
        ct_valid_d = 1'b1;
        ct_data_d  = ct_d;
      end
      default: ;
    endcase
  end

  // State, datapath and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      i_q        <= '0;
      j_q        <= '0;
      si_q       <= '0;
      sj_q       <= '0;
      k_q        <= '0;
      ct_q       <= '0;
      count_q    <= '0;
      s_addr_q   <= '0;
      s_wdata_q  <= '0;
      s_wren_q   <= 1'b0;
      pt_ready_q <= 1'b0;
      ct_valid_q <= 1'b0;
      ct_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      i_q        <= i_d;
      j_q        <= j_d;
      si_q       <= si_d;
      sj_q       <= sj_d;
      k_q        <= k_d;
      ct_q       <= ct_d;
      count_q    <= count_d;
      s_addr_q   <= s_addr_d;
      s_wdata_q  <= s_wdata_d;
      s_wren_q   <= s_wren_d;
      pt_ready_q <= pt_ready_d;
      ct_valid_q <= ct_valid_d;
      ct_data_q  <= ct_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.s_addr   = s_addr_q;
  assign bus.s_wdata  = s_wdata_q;
  assign bus.s_wren   = s_wren_q;
  assign bus.pt_ready = pt_ready_q;
  assign bus.ct_valid = ct_valid_q;
  assign bus.ct_data  = ct_data_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule
